// File: rtl/h2c_byp_desc_arbiter.sv
// ----------------------------------------------------------------------------
// h2c_byp_desc_arbiter
//
// Purpose:
//   Shares the single QDMA H2C descriptor bypass port between NUM_REQ
//   descriptor requesters (translation generators, replay engines and a
//   host-driven debug source). Each grant moves one descriptor into a
//   registered output stage. That stage is held until QDMA accepts it.
//   The constant descriptor fields are driven here, so requesters only
//   supply address, length and queue id.
//
// Parameters:
//   NUM_REQ - number of requesters (2..8)
//   PORT_ID - value driven on m_h2c_byp_in_port_id
//   IDX_W   - width of the grant index, at least clog2(NUM_REQ)
//
// Ports:
//   clk, aresetn          - clock, synchronous active-low reset
//   arb_en                - 1 allows new grants; an in-flight descriptor always completes
//   s_req_vld/s_req_rdy   - per-requester handshake (rdy is one-hot or zero)
//   s_req_raddr/len/qid   - packed requester fields, requester i at slice i
//   m_h2c_byp_in_*        - QDMA H2C bypass descriptor interface
//   grant_id              - requester owning the current or last descriptor
//   busy                  - high while a descriptor is waiting for QDMA
//
// Configuration:
//   H2C_ARB_REQ0_PRIORITY_EN - when defined, requester 0 has strict priority
//   over the round-robin among requesters 1..NUM_REQ-1.
// ----------------------------------------------------------------------------
module h2c_byp_desc_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PORT_ID = 2,
   parameter int IDX_W   = 3
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic                  arb_en,
   input  logic [NUM_REQ-1:0]    s_req_vld,
   output logic [NUM_REQ-1:0]    s_req_rdy,
   input  logic [NUM_REQ*64-1:0] s_req_raddr,
   input  logic [NUM_REQ*16-1:0] s_req_len,
   input  logic [NUM_REQ*11-1:0] s_req_qid,
   output logic                  m_h2c_byp_in_st_vld,
   input  logic                  m_h2c_byp_in_st_rdy,
   output logic [63:0]           m_h2c_byp_in_raddr,
   output logic [15:0]           m_h2c_byp_in_len,
   output logic [10:0]           m_h2c_byp_in_qid,
   output logic [15:0]           m_h2c_byp_in_cidx,
   output logic [1:0]            m_h2c_byp_in_at,
   output logic                  m_h2c_byp_in_sop,
   output logic                  m_h2c_byp_in_eop,
   output logic                  m_h2c_byp_in_error,
   output logic                  m_h2c_byp_in_mrkr_req,
   output logic                  m_h2c_byp_in_no_dma,
   output logic                  m_h2c_byp_in_sdi,
   output logic [7:0]            m_h2c_byp_in_func,
   output logic [2:0]            m_h2c_byp_in_port_id,
   output logic [IDX_W-1:0]      grant_id,
   output logic                  busy
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   rr_ptr_nxt;
   logic [NUM_REQ-1:0] rr_cand;
   logic               rr_found;
   logic [IDX_W-1:0]   rr_idx;
   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic               take;
   logic [63:0]        sel_raddr;
   logic [15:0]        sel_len;
   logic [10:0]        sel_qid;
   logic               accept;

   assign accept = m_h2c_byp_in_st_vld & m_h2c_byp_in_st_rdy;

`ifdef H2C_ARB_REQ0_PRIORITY_EN
   // Requester 0 is taken out of the rotation; it is handled by the
   // strict-priority override in the winner selection below.
   assign rr_cand = s_req_vld & {{(NUM_REQ-1){1'b1}}, 1'b0};
`else
   assign rr_cand = s_req_vld;
`endif

   // Round-robin search starting at rr_ptr. The first pass looks at
   // indices at or above the pointer. The second pass wraps around to the
   // indices below it. It only matters when the first pass found nothing.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!rr_found && rr_cand[i] && (i >= int'(rr_ptr))) begin
            rr_found = 1'b1;
            rr_idx   = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!rr_found && rr_cand[i]) begin
            rr_found = 1'b1;
            rr_idx   = IDX_W'(i);
         end
      end
   end

   // Final winner and the pointer value to commit when it is granted.
   // A priority win by requester 0 leaves the rotation where it was.
   always_comb begin
      win_found = rr_found;
      win_idx   = rr_idx;
      if (rr_idx == IDX_W'(NUM_REQ - 1)) begin
         rr_ptr_nxt = '0;
      end else begin
         rr_ptr_nxt = rr_idx + IDX_W'(1);
      end
`ifdef H2C_ARB_REQ0_PRIORITY_EN
      if (s_req_vld[0]) begin
         win_found  = 1'b1;
         win_idx    = '0;
         rr_ptr_nxt = rr_ptr;
      end
`endif
   end

   // Field mux for the winning requester. The loop index keeps every
   // slice position constant.
   always_comb begin
      sel_raddr = '0;
      sel_len   = '0;
      sel_qid   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (int'(win_idx) == i) begin
            sel_raddr = s_req_raddr[64*i +: 64];
            sel_len   = s_req_len[16*i +: 16];
            sel_qid   = s_req_qid[11*i +: 11];
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. A grant moves to SEND, and the QDMA accept
   // returns to IDLE. This gives one IDLE cycle between descriptors.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (arb_en && win_found) state_nxt = ST_SEND;
         ST_SEND: if (accept)              state_nxt = ST_IDLE;
         default:                          state_nxt = ST_IDLE;
      endcase
   end

   // Output logic. The requester handshake completes combinationally in
   // the IDLE cycle of the grant. It is gated by reset, so a waiting
   // requester never sees rdy while aresetn is low.
   always_comb begin
      take      = 1'b0;
      s_req_rdy = '0;
      if (aresetn && (state == ST_IDLE) && arb_en && win_found) begin
         take = 1'b1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(win_idx) == i) s_req_rdy[i] = 1'b1;
         end
      end
   end

   // Registered descriptor stage. The fields stay unchanged after the
   // accept until the next grant overwrites them. Reset drops an
   // in-flight descriptor without a handshake.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         m_h2c_byp_in_st_vld <= 1'b0;
         m_h2c_byp_in_raddr  <= '0;
         m_h2c_byp_in_len    <= '0;
         m_h2c_byp_in_qid    <= '0;
         grant_id            <= '0;
         rr_ptr              <= '0;
      end else if (take) begin
         m_h2c_byp_in_st_vld <= 1'b1;
         m_h2c_byp_in_raddr  <= sel_raddr;
         m_h2c_byp_in_len    <= sel_len;
         m_h2c_byp_in_qid    <= sel_qid;
         grant_id            <= win_idx;
         rr_ptr              <= rr_ptr_nxt;
      end else if (accept) begin
         m_h2c_byp_in_st_vld <= 1'b0;
      end
   end

   assign busy                  = (state == ST_SEND);
   assign m_h2c_byp_in_cidx     = 16'd1;
   assign m_h2c_byp_in_at       = 2'd1;
   assign m_h2c_byp_in_sop      = 1'b1;
   assign m_h2c_byp_in_eop      = 1'b1;
   assign m_h2c_byp_in_error    = 1'b0;
   assign m_h2c_byp_in_mrkr_req = 1'b0;
   assign m_h2c_byp_in_no_dma   = 1'b0;
   assign m_h2c_byp_in_sdi      = 1'b0;
   assign m_h2c_byp_in_func     = 8'd0;
   assign m_h2c_byp_in_port_id  = 3'(PORT_ID);

endmodule

// File: tb/tb_h2c_byp_desc_arbiter.sv
// ----------------------------------------------------------------------------
// tb_h2c_byp_desc_arbiter
//
// Purpose:
//   Self-checking bench for h2c_byp_desc_arbiter with NUM_REQ=4.
//   The expected descriptors are queued when a grant is expected. They
//   are popped and compared whenever QDMA accepts a descriptor.
//   Per-cycle handshake expectations come from a vector table. The
//   multi-cycle cases (stall, reset in SEND, requester-0 priority) are
//   handled by hand-written sequences.
//
// Ports: none (top-level bench).
//
// Configuration:
//   H2C_ARB_REQ0_PRIORITY_EN - when defined, the expected grant order and
//   the priority sequence follow the strict requester-0 priority variant.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_h2c_byp_desc_arbiter;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 3;
   localparam int PORT_ID = 2;
   localparam int NVEC    = 19;

   logic                  clk = 1'b0;
   logic                  aresetn;
   logic                  arb_en;
   logic [NUM_REQ-1:0]    s_req_vld;
   logic [NUM_REQ-1:0]    s_req_rdy;
   logic [NUM_REQ*64-1:0] s_req_raddr;
   logic [NUM_REQ*16-1:0] s_req_len;
   logic [NUM_REQ*11-1:0] s_req_qid;
   logic                  st_vld;
   logic                  st_rdy;
   logic [63:0]           raddr;
   logic [15:0]           len;
   logic [10:0]           qid;
   logic [15:0]           cidx;
   logic [1:0]            at;
   logic                  sop;
   logic                  eop;
   logic                  error;
   logic                  mrkr_req;
   logic                  no_dma;
   logic                  sdi;
   logic [7:0]            func;
   logic [2:0]            port_id;
   logic [IDX_W-1:0]      grant_id;
   logic                  busy;

   logic [63:0] req_addr [NUM_REQ];
   logic [15:0] req_len  [NUM_REQ];
   logic [10:0] req_qid  [NUM_REQ];

   typedef struct {
      logic [IDX_W-1:0] id;
      logic [63:0]      raddr;
      logic [15:0]      len;
      logic [10:0]      qid;
   } desc_t;

   typedef struct {
      logic [3:0] vld;
      logic       arb_en;
      logic       st_rdy;
      logic [3:0] exp_rdy;
      logic       exp_st_vld;
      logic       exp_busy;
   } vec_t;

   desc_t exp_q [$];
   vec_t  vecs [NVEC];
   int    order [6];
   int    checks = 0;
   int    errors = 0;

   h2c_byp_desc_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PORT_ID (PORT_ID),
      .IDX_W   (IDX_W)
   ) dut (
      .clk                   (clk),
      .aresetn               (aresetn),
      .arb_en                (arb_en),
      .s_req_vld             (s_req_vld),
      .s_req_rdy             (s_req_rdy),
      .s_req_raddr           (s_req_raddr),
      .s_req_len             (s_req_len),
      .s_req_qid             (s_req_qid),
      .m_h2c_byp_in_st_vld   (st_vld),
      .m_h2c_byp_in_st_rdy   (st_rdy),
      .m_h2c_byp_in_raddr    (raddr),
      .m_h2c_byp_in_len      (len),
      .m_h2c_byp_in_qid      (qid),
      .m_h2c_byp_in_cidx     (cidx),
      .m_h2c_byp_in_at       (at),
      .m_h2c_byp_in_sop      (sop),
      .m_h2c_byp_in_eop      (eop),
      .m_h2c_byp_in_error    (error),
      .m_h2c_byp_in_mrkr_req (mrkr_req),
      .m_h2c_byp_in_no_dma   (no_dma),
      .m_h2c_byp_in_sdi      (sdi),
      .m_h2c_byp_in_func     (func),
      .m_h2c_byp_in_port_id  (port_id),
      .grant_id              (grant_id),
      .busy                  (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Pack the per-requester field arrays onto the DUT buses.
   always_comb begin
      s_req_raddr = '0;
      s_req_len   = '0;
      s_req_qid   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         s_req_raddr[64*i +: 64] = req_addr[i];
         s_req_len[16*i +: 16]   = req_len[i];
         s_req_qid[11*i +: 11]   = req_qid[i];
      end
   end

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected(input int g);
      desc_t d;
      d.id    = IDX_W'(g);
      d.raddr = req_addr[g];
      d.len   = req_len[g];
      d.qid   = req_qid[g];
      exp_q.push_back(d);
   endtask

   function automatic vec_t mk(input logic [3:0] vld, input logic en, input logic rdy,
                               input logic [3:0] exp_rdy, input logic exp_vld, input logic exp_busy);
      vec_t v;
      v.vld        = vld;
      v.arb_en     = en;
      v.st_rdy     = rdy;
      v.exp_rdy    = exp_rdy;
      v.exp_st_vld = exp_vld;
      v.exp_busy   = exp_busy;
      return v;
   endfunction

   // Drive one table row. A row that expects a grant queues the
   // descriptor of the requester it names.
   task automatic applyStimulus(input vec_t v);
      s_req_vld = v.vld;
      arb_en    = v.arb_en;
      st_rdy    = v.st_rdy;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (v.exp_rdy[i]) push_expected(i);
      end
   endtask

   task automatic checkOutput(input vec_t v, input int row);
      @(negedge clk);
      check_val($sformatf("row%0d s_req_rdy", row), 64'(s_req_rdy), 64'(v.exp_rdy));
      check_val($sformatf("row%0d st_vld", row), 64'(st_vld), 64'(v.exp_st_vld));
      check_val($sformatf("row%0d busy", row), 64'(busy), 64'(v.exp_busy));
   endtask

   // Scoreboard: every accepted descriptor must match the oldest expected one.
   initial begin
      desc_t e;
      forever begin
         @(negedge clk);
         if (aresetn === 1'b1 && st_vld === 1'b1 && st_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected descriptor: got grant_id %0d, expected none", grant_id);
            end else begin
               e = exp_q.pop_front();
               check_val("sb grant_id", 64'(grant_id), 64'(e.id));
               check_val("sb raddr", raddr, e.raddr);
               check_val("sb len", 64'(len), 64'(e.len));
               check_val("sb qid", 64'(qid), 64'(e.qid));
            end
         end
      end
   end

   // Main test sequence.
   initial begin
      aresetn   = 1'b0;
      arb_en    = 1'b0;
      s_req_vld = '0;
      st_rdy    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_addr[i] = 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h1_0000;
         req_len[i]  = 16'h0040 + 16'(i);
         req_qid[i]  = 11'h100 + 11'(i);
      end
      req_addr[1] = 64'h0000_1234_5678_9000;
      req_len[1]  = 16'd8;
      req_qid[1]  = 11'd1;

`ifdef H2C_ARB_REQ0_PRIORITY_EN
      order = '{0, 0, 0, 0, 0, 0};
`else
      order = '{0, 1, 2, 3, 0, 1};
`endif
      for (int k = 0; k < 6; k++) begin
         vecs[2*k]   = mk(4'b1111, 1'b1, 1'b1, 4'(1 << order[k]), 1'b0, 1'b0);
         vecs[2*k+1] = mk(4'b1111, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
      end
      vecs[12] = mk(4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
      vecs[13] = mk(4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
      vecs[14] = mk(4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
      vecs[15] = mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
      vecs[16] = mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
      vecs[17] = mk(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1);
      vecs[18] = mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);

      // Reset state.
      repeat (2) tick();
      @(negedge clk);
      check_val("reset st_vld", 64'(st_vld), 64'd0);
      check_val("reset busy", 64'(busy), 64'd0);
      check_val("reset grant_id", 64'(grant_id), 64'd0);
      check_val("reset s_req_rdy", 64'(s_req_rdy), 64'd0);
      check_val("reset raddr", raddr, 64'd0);
      check_val("reset len", 64'(len), 64'd0);
      check_val("reset qid", 64'(qid), 64'd0);

      // Single descriptor from requester 1, checking latency and the constant fields.
      tick();
      aresetn   = 1'b1;
      arb_en    = 1'b1;
      st_rdy    = 1'b1;
      s_req_vld = 4'b0010;
      @(negedge clk);
      check_val("t1 s_req_rdy", 64'(s_req_rdy), 64'b0010);
      check_val("t1 st_vld early", 64'(st_vld), 64'd0);
      push_expected(1);
      tick();
      s_req_vld = 4'b0000;
      @(negedge clk);
      check_val("t1 st_vld", 64'(st_vld), 64'd1);
      check_val("t1 busy", 64'(busy), 64'd1);
      check_val("t1 s_req_rdy send", 64'(s_req_rdy), 64'd0);
      check_val("t1 at", 64'(at), 64'd1);
      check_val("t1 cidx", 64'(cidx), 64'd1);
      check_val("t1 port_id", 64'(port_id), 64'(PORT_ID));
      check_val("t1 sop/eop", 64'({sop, eop}), 64'b11);
      check_val("t1 zero flags", 64'({error, mrkr_req, no_dma, sdi}), 64'd0);
      check_val("t1 func", 64'(func), 64'd0);
      tick();
      @(negedge clk);
      check_val("t1 st_vld after accept", 64'(st_vld), 64'd0);
      check_val("t1 busy after accept", 64'(busy), 64'd0);
      check_val("t1 raddr retained", raddr, 64'h0000_1234_5678_9000);

      // Return rr_ptr to 0, then run the vector table: the rotation
      // with all four requesters valid, followed by the arb_en cases.
      tick();
      aresetn = 1'b0;
      s_req_vld = '0;
      tick();
      aresetn = 1'b1;
      for (int r = 0; r < NVEC; r++) begin
         applyStimulus(vecs[r]);
         checkOutput(vecs[r], r);
         tick();
      end

      // QDMA stalls for 10 cycles on a descriptor from requester 2.
      // The other requesters are valid meanwhile and must not see rdy.
      arb_en    = 1'b1;
      st_rdy    = 1'b0;
      s_req_vld = 4'b0100;
      @(negedge clk);
      check_val("stall grant rdy", 64'(s_req_rdy), 64'b0100);
      push_expected(2);
      tick();
      s_req_vld = 4'b1011;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check_val($sformatf("stall c%0d st_vld", c), 64'(st_vld), 64'd1);
         check_val($sformatf("stall c%0d s_req_rdy", c), 64'(s_req_rdy), 64'd0);
         check_val($sformatf("stall c%0d raddr", c), raddr, req_addr[2]);
         check_val($sformatf("stall c%0d len", c), 64'(len), 64'(req_len[2]));
         check_val($sformatf("stall c%0d qid", c), 64'(qid), 64'(req_qid[2]));
         check_val($sformatf("stall c%0d grant_id", c), 64'(grant_id), 64'd2);
         tick();
      end
      s_req_vld = 4'b0000;
      st_rdy    = 1'b1;
      @(negedge clk);
      check_val("stall accept st_vld", 64'(st_vld), 64'd1);
      tick();
      @(negedge clk);
      check_val("stall idle st_vld", 64'(st_vld), 64'd0);
      check_val("stall idle busy", 64'(busy), 64'd0);

      // Reset during SEND while QDMA is stalled. Requester 3 is pending
      // throughout and is granted once reset is released.
      tick();
      st_rdy    = 1'b0;
      s_req_vld = 4'b0001;
      @(negedge clk);
      check_val("rst-send grant rdy", 64'(s_req_rdy), 64'b0001);
      tick();
      s_req_vld = 4'b1000;
      @(negedge clk);
      check_val("rst-send st_vld", 64'(st_vld), 64'd1);
      check_val("rst-send s_req_rdy", 64'(s_req_rdy), 64'd0);
      tick();
      aresetn = 1'b0;
      @(negedge clk);
      check_val("rst-send rdy pre-edge", 64'(s_req_rdy), 64'd0);
      tick();
      @(negedge clk);
      check_val("rst-send dropped st_vld", 64'(st_vld), 64'd0);
      check_val("rst-send dropped busy", 64'(busy), 64'd0);
      check_val("rst-send rdy in reset", 64'(s_req_rdy), 64'd0);
      tick();
      aresetn = 1'b1;
      st_rdy  = 1'b1;
      @(negedge clk);
      check_val("post-rst grant rdy", 64'(s_req_rdy), 64'b1000);
      push_expected(3);
      tick();
      s_req_vld = 4'b0000;
      @(negedge clk);
      check_val("post-rst st_vld", 64'(st_vld), 64'd1);
      tick();
      @(negedge clk);
      check_val("post-rst idle", 64'(st_vld), 64'd0);

`ifdef H2C_ARB_REQ0_PRIORITY_EN
      // Requester 0 wins every time against requester 2. Once it is
      // removed, requester 2 is granted.
      tick();
      s_req_vld = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val($sformatf("prio g%0d rdy", k), 64'(s_req_rdy), 64'b0001);
         push_expected(0);
         tick();
         @(negedge clk);
         check_val($sformatf("prio g%0d st_vld", k), 64'(st_vld), 64'd1);
         tick();
      end
      s_req_vld = 4'b0100;
      @(negedge clk);
      check_val("prio req2 rdy", 64'(s_req_rdy), 64'b0100);
      push_expected(2);
      tick();
      s_req_vld = 4'b0000;
      @(negedge clk);
`endif

      repeat (2) tick();
      check_val("scoreboard drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/h2c_byp_desc_arbiter.md
Name: h2c_byp_desc_arbiter

Overview:
- Shares the single QDMA H2C descriptor bypass port (m_h2c_byp_in_*) between NUM_REQ descriptor requesters: translation generators, replay engines and a host-driven debug source.
- Arbitration is round-robin. Each grant latches exactly one descriptor into a registered output stage, which is held until QDMA accepts it.
- Sits between the requesters and the QDMA IP. Drives the constant descriptor fields so requesters supply only address, length and queue.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PORT_ID, 2, value driven on m_h2c_byp_in_port_id.
- IDX_W, 3, width of grant index; must be >= clog2(NUM_REQ).

Ports:
- clk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- arb_en  in  1  1 = new grants allowed; 0 = the in-flight descriptor completes, then no further grants
- s_req_vld  in  NUM_REQ  per-requester descriptor valid
- s_req_rdy  out  NUM_REQ  per-requester accept; one-hot or zero
- s_req_raddr  in  NUM_REQ*64  packed descriptor addresses; requester i at [64i+63:64i]
- s_req_len  in  NUM_REQ*16  packed lengths
- s_req_qid  in  NUM_REQ*11  packed QIDs
- m_h2c_byp_in_st_vld  out  1  descriptor valid to QDMA
- m_h2c_byp_in_st_rdy  in  1  QDMA ready
- m_h2c_byp_in_raddr  out  64  latched address
- m_h2c_byp_in_len  out  16  latched length
- m_h2c_byp_in_qid  out  11  latched QID
- m_h2c_byp_in_cidx  out  16  constant 1
- m_h2c_byp_in_at  out  2  constant 1
- m_h2c_byp_in_sop / eop  out  1 each  constant 1
- m_h2c_byp_in_error, mrkr_req, no_dma, sdi  out  1 each  constant 0
- m_h2c_byp_in_func  out  8  constant 0
- m_h2c_byp_in_port_id  out  3  constant PORT_ID
- grant_id  out  IDX_W  index of the requester owning the current or last descriptor
- busy  out  1  high while in SEND

Behaviour:
- Reset is synchronous active-low on clk (aresetn). The following all clear at the first clock edge with aresetn=0, regardless of state:
  - st_vld=0, raddr=0, len=0, qid=0
  - grant_id=0, busy=0, s_req_rdy=0
  - state=IDLE, rr_ptr=0
- An in-flight descriptor is dropped on reset, with no handshake toward QDMA.
- State machine: IDLE, SEND.
- IDLE:
  - Grant condition: arb_en=1 and any s_req_vld=1.
  - Winner g = first requester with vld=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ (wrap-around).
  - s_req_rdy[g]=1 combinationally in that same cycle; the handshake completes then.
  - On the clock edge:
    - raddr/len/qid <= requester g fields
    - st_vld <= 1, grant_id <= g, busy <= 1
    - rr_ptr <= (g+1) mod NUM_REQ
    - state <= SEND
  - If there is no request or arb_en=0: s_req_rdy=0 and the state stays IDLE.
- SEND:
  - s_req_rdy=0 throughout.
  - Outputs are held stable while st_rdy=0.
  - On st_vld & st_rdy: st_vld <= 0, busy <= 0, state <= IDLE.
  - raddr/len/qid keep their value until the next grant.
- Latency: request vld seen in IDLE → st_vld high on the next cycle. Minimum spacing between descriptors is 2 cycles (one IDLE cycle after each accept).
- Requesters must hold vld and their fields stable until their rdy. A vld dropped before grant is legal and is simply not granted.
- arb_en deasserted during SEND does not affect the current descriptor.
- A requester that is continuously valid is granted at least once every NUM_REQ grants.
- s_req_rdy never has more than one bit set; it is all-zero in SEND and during reset.

Optional Feature:
- Macro: H2C_ARB_REQ0_PRIORITY_EN.
- Defined: requester 0 has strict priority. If s_req_vld[0]=1 in IDLE it wins regardless of rr_ptr, and rr_ptr is unchanged. Round-robin over requesters 1..NUM_REQ-1 otherwise, with rr_ptr updated as normal. Intended for the latency-critical TLB-miss path.
- Undefined: pure round-robin over all requesters as above.

Test Plan:
- Reset, then req1 vld with raddr=0x0000_1234_5678_9000, len=8, qid=1, QDMA rdy=1:
  - s_req_rdy=0b0010 for 1 cycle; st_vld next cycle with those fields, grant_id=1.
  - st_vld low after 1 cycle.
  - Constant fields: at=1, cidx=1, port_id=2.
- All 4 requesters continuously valid, rdy=1, rr_ptr=0: grant order 0,1,2,3,0,1; descriptors spaced every 2 cycles.
- QDMA rdy held low 10 cycles after grant to req2:
  - st_vld and fields stable for all 10 cycles; no s_req_rdy pulses.
  - Accept on cycle 11, then IDLE.
- arb_en=0 with req0 vld: no grant, st_vld=0. arb_en=1: grant on the same cycle. arb_en dropped during SEND: descriptor still completes.
- Reset asserted during SEND with rdy=0: next edge st_vld=0 and busy=0. After release, the pending req3 is granted first (rr_ptr=0, only req3 vld).
- With H2C_ARB_REQ0_PRIORITY_EN, req0 and req2 both continuously valid: req0 granted every time. Req0 removed: req2 granted.
